// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the main-memory arbiter: controller state encoding,
//   requester identity, default refill-line width and the round-robin picker.
package mem_arbiter_pkg;

  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_D  = 1'b1
  } req_e;

  // A lone request always wins; on a tie the requester not served last wins.
  function automatic req_e rr_pick(input logic ic_req, input logic d_req,
                                   input req_e last_gnt);
    if (ic_req && d_req) begin
      return (last_gnt == REQ_IC) ? REQ_D : REQ_IC;
    end else if (d_req) begin
      return REQ_D;
    end else begin
      return REQ_IC;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory port between the icache line refill and the
//   CPU data port. Round-robin grant, drives the active-low memory strobes,
//   waits out mem_hold_i / mem_line_done_i, latches returned data and pulses
//   the winner's done. A transfer that never completes is aborted after
//   TIMEOUT wait cycles (TIMEOUT must be 1..65535) and flagged with err_o.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   ic_req_i/ic_addr_i      icache refill request and line address
//   ic_line_o/ic_done_o     refilled line, completion pulse
//   d_req_i/d_we_n_i/d_bw_i data request, 0=write, byte-write select
//   d_addr_i/d_wdata_i      data address / write data
//   d_rdata_o/d_done_o      read data, completion pulse
//   err_o                   abort pulse, coincides with the aborted done
//   mem_*_o                 memory strobes (active-low), bw, address, wdata
//   mem_rdata_i/mem_line_i  memory word / line read data
//   mem_hold_i              memory busy
//   mem_line_done_i         line read complete
//
// state | meaning
// IDLE  | sample requests, grant round-robin
// ISSUE | strobes driven for the granted transfer, hold ignored
// WAIT  | strobes held, waiting for completion or timeout
// DONE  | strobes released, winner's done (and err on abort) pulsed
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req_i,
  input  logic [31:0]       ic_addr_i,
  output logic [LINE_W-1:0] ic_line_o,
  output logic              ic_done_o,
  input  logic              d_req_i,
  input  logic              d_we_n_i,
  input  logic              d_bw_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_done_o,
  output logic              err_o,
  output logic              mem_ce_n_o,
  output logic              mem_oe_n_o,
  output logic              mem_we_n_o,
  output logic              mem_mr_n_o,
  output logic              mem_bw_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_hold_i,
  input  logic              mem_line_done_i
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  req_e              last_gnt_q, last_gnt_d;
  req_e              gnt_q, gnt_d;
  logic              is_wr_q, is_wr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              mr_n_q, mr_n_d;
  logic              bw_q, bw_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              ic_done_q, ic_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              xfer_done;
  logic              timed_out;

  // Line refills are always line-aligned, so the low address bits are dropped.
  logic unused_ic_addr_lsbs;
  assign unused_ic_addr_lsbs = ^ic_addr_i[4:0];

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    is_wr_d    = is_wr_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    mr_n_d     = mr_n_q;
    bw_d       = bw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    line_d     = line_q;
    wait_cnt_d = wait_cnt_q;
    ic_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = 1'b0;

    xfer_done = (gnt_q == REQ_IC) ? mem_line_done_i : ~mem_hold_i;
    timed_out = (wait_cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (ic_req_i || d_req_i) begin
          gnt_d   = rr_pick(ic_req_i, d_req_i, last_gnt_q);
          state_d = ISSUE;
          ce_n_d  = 1'b0;
          // Strobes are registered, so they are loaded here to be valid in ISSUE.
          if (gnt_d == REQ_IC) begin
            is_wr_d = 1'b0;
            oe_n_d  = 1'b0;
            we_n_d  = 1'b1;
            mr_n_d  = 1'b0;
            bw_d    = 1'b0;
            addr_d  = {ic_addr_i[31:5], 5'b0};
            wdata_d = 32'h0;
          end else begin
            is_wr_d = ~d_we_n_i;
            oe_n_d  = ~d_we_n_i;
            we_n_d  = d_we_n_i;
            mr_n_d  = 1'b1;
            bw_d    = d_bw_i;
            addr_d  = d_addr_i;
            wdata_d = d_we_n_i ? 32'h0 : d_wdata_i;
          end
        end
      end

      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = 16'h0;
      end

      WAIT: begin
        // Completion wins over timeout when both land on the same cycle.
        if (xfer_done || timed_out) begin
          state_d    = DONE;
          last_gnt_d = gnt_q;
          err_d      = ~xfer_done;
          wait_cnt_d = 16'h0;
          if (gnt_q == REQ_IC) begin
            ic_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
          if (xfer_done) begin
            if (gnt_q == REQ_IC) begin
              line_d = mem_line_i;
            end else if (!is_wr_q) begin
              rdata_d = mem_rdata_i;
            end
          end
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          mr_n_d  = 1'b1;
          bw_d    = 1'b0;
          addr_d  = 32'h0;
          wdata_d = 32'h0;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'h1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_D;
      gnt_q      <= REQ_IC;
      is_wr_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      mr_n_q     <= 1'b1;
      bw_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      line_q     <= '0;
      ic_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      is_wr_q    <= is_wr_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      mr_n_q     <= mr_n_d;
      bw_q       <= bw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      line_q     <= line_d;
      ic_done_q  <= ic_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_ce_n_o  = ce_n_q;
  assign mem_oe_n_o  = oe_n_q;
  assign mem_we_n_o  = we_n_q;
  assign mem_mr_n_o  = mr_n_q;
  assign mem_bw_o    = bw_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign d_rdata_o   = rdata_q;
  assign ic_line_o   = line_q;
  assign ic_done_o   = ic_done_q;
  assign d_done_o    = d_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios plus randomized traffic for mem_arbiter. A
//   transaction-level model (grant cycle, completion cycle, captured request)
//   predicts every output on every cycle.
module tb_mem_arbiter;

  localparam int TO = 20;
  localparam int LW = 256;
  localparam logic [LW-1:0] LINE_K =
    256'h0706050403020100_0f0e0d0c0b0a0908_1716151413121110_1f1e1d1c1b1a1918;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ic_req_i = 0, d_req_i = 0, d_we_n_i = 1, d_bw_i = 0;
  logic [31:0]   ic_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
  logic [LW-1:0] mem_line_i = '0;
  logic          mem_hold_i = 0, mem_line_done_i = 0;
  logic [LW-1:0] ic_line_o;
  logic [31:0]   d_rdata_o, mem_addr_o, mem_wdata_o;
  logic          ic_done_o, d_done_o, err_o;
  logic          mem_ce_n_o, mem_oe_n_o, mem_we_n_o, mem_mr_n_o, mem_bw_o;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_line_o(ic_line_o), .ic_done_o(ic_done_o),
    .d_req_i(d_req_i), .d_we_n_i(d_we_n_i), .d_bw_i(d_bw_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .err_o(err_o),
    .mem_ce_n_o(mem_ce_n_o), .mem_oe_n_o(mem_oe_n_o), .mem_we_n_o(mem_we_n_o),
    .mem_mr_n_o(mem_mr_n_o), .mem_bw_o(mem_bw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_line_i(mem_line_i),
    .mem_hold_i(mem_hold_i), .mem_line_done_i(mem_line_done_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkl(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = icache done, 1 = data done, -1 = budget expired
  task automatic wait_done(input string nm, input int budget, output int which);
    which = -1;
    for (int i = 0; i < budget && which < 0; i++) begin
      step();
      if (ic_done_o) which = 0;
      else if (d_done_o) which = 1;
    end
    if (which < 0) begin
      n_chk++;
      $display("FAIL %s: got no done want done within %0d cycles", nm, budget);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic          m_open = 0, m_win_d = 0, m_wr = 0, m_bw = 0, m_last_d = 1, m_err = 0;
  logic          m_fin, m_to;
  int            m_g = 0, m_free = 0, m_done_at = -1;
  logic [31:0]   m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [LW-1:0] m_line = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_open = 0; m_free = 0; m_done_at = -1; m_last_d = 1; m_err = 0;
      m_rdata = 0; m_line = '0;
      chk1("rst_ce_n", mem_ce_n_o, 1'b1);
      chk1("rst_oe_n", mem_oe_n_o, 1'b1);
      chk1("rst_we_n", mem_we_n_o, 1'b1);
      chk1("rst_mr_n", mem_mr_n_o, 1'b1);
      chk32("rst_addr", mem_addr_o, 32'h0);
      chk32("rst_wdata", mem_wdata_o, 32'h0);
      chk1("rst_ic_done", ic_done_o, 1'b0);
      chk1("rst_d_done", d_done_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chk32("rst_rdata", d_rdata_o, 32'h0);
      chkl("rst_line", ic_line_o, '0);
    end else begin
      chk1("m_ce_n", mem_ce_n_o, !m_open);
      chk1("m_oe_n", mem_oe_n_o, !m_open || (m_win_d && m_wr));
      chk1("m_we_n", mem_we_n_o, !(m_open && m_win_d && m_wr));
      chk1("m_mr_n", mem_mr_n_o, !(m_open && !m_win_d));
      chk1("m_bw", mem_bw_o, m_open && m_win_d && m_bw);
      chk32("m_addr", mem_addr_o, m_open ? m_addr : 32'h0);
      if (!m_open) chk32("m_wdata_idle", mem_wdata_o, 32'h0);
      else if (m_win_d && m_wr) chk32("m_wdata", mem_wdata_o, m_wdata);
      chk1("m_ic_done", ic_done_o, (cyc == m_done_at) && !m_win_d);
      chk1("m_d_done", d_done_o, (cyc == m_done_at) && m_win_d);
      chk1("m_err", err_o, (cyc == m_done_at) && m_err);
      chk32("m_rdata", d_rdata_o, m_rdata);
      chkl("m_line", ic_line_o, m_line);
      // advance by the rules using the inputs the DUT samples at the next edge
      if (m_open) begin
        if (cyc >= m_g + 2) begin
          m_fin = m_win_d ? !mem_hold_i : mem_line_done_i;
          m_to  = (cyc - (m_g + 2)) == TO - 1;
          if (m_fin || m_to) begin
            if (m_fin && !m_win_d) m_line = mem_line_i;
            if (m_fin && m_win_d && !m_wr) m_rdata = mem_rdata_i;
            m_err = !m_fin; m_last_d = m_win_d; m_open = 0;
            m_done_at = cyc + 1; m_free = cyc + 2;
          end
        end
      end else if (cyc >= m_free && (ic_req_i || d_req_i)) begin
        m_win_d = (ic_req_i && d_req_i) ? !m_last_d : d_req_i;
        m_open  = 1; m_g = cyc;
        m_wr    = m_win_d && !d_we_n_i;
        m_bw    = m_win_d && d_bw_i;
        m_addr  = m_win_d ? d_addr_i : {ic_addr_i[31:5], 5'b0};
        m_wdata = d_wdata_i;
      end
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  int w, n0, bias;

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) step();
    chk1("reset_ce_n", mem_ce_n_o, 1'b1);
    chk32("reset_addr", mem_addr_o, 32'h0);
    reset_n = 1'b1;

    // both requesters permanently high from reset: IC, D, IC, D
    ic_req_i = 1; d_req_i = 1; d_we_n_i = 1; mem_hold_i = 0; mem_line_done_i = 1;
    for (int t = 0; t < 4; t++) begin
      wait_done("rr_tie", 20, w);
      chk32($sformatf("rr_order%0d", t), w, (t % 2 == 0) ? 32'd0 : 32'd1);
    end
    ic_req_i = 0; d_req_i = 0; mem_line_done_i = 0;
    repeat (2) step();

    // data read, hold 3 cycles after ISSUE
    d_req_i = 1; d_we_n_i = 1; d_bw_i = 0; d_addr_i = 32'h1001_0008;
    mem_hold_i = 1; mem_rdata_i = 32'h0; n0 = cyc;
    step();
    chk1("rd_issue_oe_n", mem_oe_n_o, 1'b0);
    chk1("rd_issue_mr_n", mem_mr_n_o, 1'b1);
    chk32("rd_issue_addr", mem_addr_o, 32'h1001_0008);
    repeat (4) step();
    mem_hold_i = 0; mem_rdata_i = 32'hDEAD_BEEF;
    wait_done("rd_done", 10, w);
    chk32("rd_latency", cyc - n0, 32'd6);
    chk32("rd_who", w, 32'd1);
    chk32("rd_data", d_rdata_o, 32'hDEAD_BEEF);
    d_req_i = 0; mem_rdata_i = 32'h0;
    repeat (2) step();

    // data write; request fields change mid-WAIT and must be ignored
    d_req_i = 1; d_we_n_i = 0; d_bw_i = 1; d_addr_i = 32'h2000_0040;
    d_wdata_i = 32'h1234_5678; mem_hold_i = 1;
    step();
    chk1("wr_we_n", mem_we_n_o, 1'b0);
    chk1("wr_oe_n", mem_oe_n_o, 1'b1);
    chk1("wr_bw", mem_bw_o, 1'b1);
    chk32("wr_wdata", mem_wdata_o, 32'h1234_5678);
    step();
    d_wdata_i = 32'hFFFF_FFFF; d_addr_i = 32'h0; d_bw_i = 0;
    chk32("wr_wdata_wait", mem_wdata_o, 32'h1234_5678);
    step();
    chk32("wr_wdata_held", mem_wdata_o, 32'h1234_5678);
    chk32("wr_addr_held", mem_addr_o, 32'h2000_0040);
    chk1("wr_bw_held", mem_bw_o, 1'b1);
    mem_hold_i = 0; mem_rdata_i = 32'hBAD0_BAD0;
    wait_done("wr_done", 10, w);
    chk32("wr_who", w, 32'd1);
    chk1("wr_no_ic_done", ic_done_o, 1'b0);
    chk32("wr_rdata_kept", d_rdata_o, 32'hDEAD_BEEF);
    d_req_i = 0; d_we_n_i = 1;
    repeat (2) step();

    // icache refill, 16 WAIT cycles then line_done
    ic_req_i = 1; ic_addr_i = 32'h0040_0124; mem_hold_i = 1; mem_line_done_i = 0;
    mem_line_i = ~LINE_K;
    step();
    chk32("ic_issue_addr", mem_addr_o, 32'h0040_0120);
    chk1("ic_issue_mr_n", mem_mr_n_o, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk1("ic_wait_mr_n", mem_mr_n_o, 1'b0);
      chk32("ic_wait_addr", mem_addr_o, 32'h0040_0120);
    end
    step();
    mem_line_done_i = 1; mem_line_i = LINE_K;
    wait_done("ic_done", 5, w);
    mem_line_done_i = 0; mem_line_i = '0;
    chk32("ic_who", w, 32'd0);
    chkl("ic_line", ic_line_o, LINE_K);
    chk1("ic_strobes_off", mem_ce_n_o, 1'b1);
    ic_req_i = 0;
    repeat (2) step();

    // memory never completes: abort after TO wait cycles
    d_req_i = 1; d_we_n_i = 1; d_addr_i = 32'h3000_0000; mem_hold_i = 1;
    mem_rdata_i = 32'h5555_5555; n0 = cyc;
    wait_done("to_done", TO + 10, w);
    chk32("to_latency", cyc - n0, 32'(TO + 2));
    chk32("to_who", w, 32'd1);
    chk1("to_err", err_o, 1'b1);
    chk32("to_rdata_kept", d_rdata_o, 32'hDEAD_BEEF);
    // tie right after the abort goes to icache
    ic_req_i = 1; mem_hold_i = 0; mem_line_done_i = 1;
    wait_done("to_next", 10, w);
    chk32("to_next_is_ic", w, 32'd0);
    ic_req_i = 0;
    wait_done("to_next_d", 10, w);
    chk32("to_then_d", w, 32'd1);
    d_req_i = 0; mem_line_done_i = 0;
    repeat (2) step();

    // async reset during an icache WAIT
    ic_req_i = 1; ic_addr_i = 32'h0080_0000; mem_hold_i = 1; mem_line_done_i = 0;
    repeat (3) step();
    #2 reset_n = 0;
    #1;
    chk1("arst_ce_n", mem_ce_n_o, 1'b1);
    chk1("arst_oe_n", mem_oe_n_o, 1'b1);
    chk1("arst_mr_n", mem_mr_n_o, 1'b1);
    chk32("arst_addr", mem_addr_o, 32'h0);
    ic_req_i = 0;
    repeat (2) begin
      step();
      chk1("arst_no_done", ic_done_o, 1'b0);
    end
    reset_n = 1;
    d_req_i = 1; d_we_n_i = 1; d_addr_i = 32'h0000_0100; mem_hold_i = 0;
    mem_rdata_i = 32'hCAFE_F00D; n0 = cyc;
    wait_done("post_rst", 10, w);
    chk32("post_rst_latency", cyc - n0, 32'd3);
    chk32("post_rst_data", d_rdata_o, 32'hCAFE_F00D);
    d_req_i = 0;
    step();

    // randomized traffic
    bias = 1;
    for (int s = 0; s < 1500; s++) begin
      if (s % 150 == 0) bias = $urandom_range(1, 8);
      mem_hold_i      = ($urandom_range(0, bias) != 0);
      mem_line_done_i = ($urandom_range(0, 2 * bias) == 0);
      mem_rdata_i     = $urandom;
      mem_line_i      = rand_line();
      if (ic_done_o) ic_req_i = 0;
      else if (!ic_req_i && $urandom_range(0, 2) == 0) begin
        ic_req_i = 1; ic_addr_i = $urandom;
      end
      if (d_done_o) d_req_i = 0;
      else if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_addr_i = $urandom; d_wdata_i = $urandom;
        d_we_n_i = 1'($urandom_range(0, 1)); d_bw_i = 1'($urandom_range(0, 1));
      end
      step();
    end
    ic_req_i = 0; d_req_i = 0; mem_hold_i = 0; mem_line_done_i = 1;
    repeat (TO + 6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
